i2c_reg_target: RTL
===================

Name: i2c_reg_target

Overview:
- Parametrised I2C target (slave) with an internal register file. It replaces the fixed single-purpose serial config port of the sine generator.
- Synchronises SCL/SDA into clk, decodes START/STOP/repeated START, and supports multi-byte writes and reads with pointer auto-increment.
- Drives SDA open-drain via an output-enable.
- Register contents go to the datapath (e.g. sine channel frequency/amplitude) as a flat bus.

Parameters:
- DEV_ADDR, 7'h2A, 7-bit bus address this target answers.
- WL, 8, register/data byte width. Fixed to 8 for I2C framing; parameterised for the package.
- NUM_REGS, 8, number of WL-bit registers. Must be a power of two, 2..256.
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronisers (>=2).

Ports:
- clk  in  1  system clock; >= 8x SCL rate.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable. When low, bus is ignored, sda_oe=0 and FSM is held in IDLE.
- scl_i  in  1  raw SCL pin.
- sda_i  in  1  raw SDA pin (wired-AND level).
- sda_oe  out  1  1 = pull SDA low. The pad drives 0 when asserted.
- regs_o  out  NUM_REGS*WL  flat register file; reg k at [k*WL +: WL].
- wr_stb  out  1  one-cycle pulse when a register is written.
- wr_idx  out  $clog2(NUM_REGS)  index of the register written; valid with wr_stb.
- busy  out  1  high from START addressed to us until STOP or NACK-return-to-IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - all registers 0, pointer 0, sda_oe=0, wr_stb=0, busy=0, FSM=IDLE.
  - Synchroniser flops reset to 1 (bus idle).
  - Reset mid-transfer aborts immediately and releases SDA.
- Inputs pass SYNC_STAGES flops, then one edge-detect flop. All decisions use the synchronised signals s_scl/s_sda.
- START: s_sda falls while s_scl=1. STOP: s_sda rises while s_scl=1.
  - Both are recognised in any state and take priority over bit sampling.
  - START → ADDR (bit count 0). STOP → IDLE, with busy=0 and sda_oe=0 on the next cycle.
- Data bits are sampled on the s_scl rising edge. sda_oe changes only on the cycle after an s_scl falling edge, never while s_scl=1.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT.
- IDLE: waits for START.
- ADDR: shifts 8 bits MSB first.
  - If addr[7:1]==DEV_ADDR: assert sda_oe after the 8th falling edge → ADDR_ACK; busy=1.
  - Otherwise → WAIT (no ACK).
- ADDR_ACK: release sda_oe on the next falling edge.
  - R/W=0 → PTR.
  - R/W=1 → RDATA; the first data bit is driven on that same falling edge.
- PTR: 8 bits. pointer <= byte mod NUM_REGS (upper bits ignored). ACK → PTR_ACK → WDATA.
- WDATA: 8 bits.
  - After the 8th rising edge: reg[pointer] <= byte, wr_stb=1 for one cycle with wr_idx=pointer, pointer increments mod NUM_REGS (wrap NUM_REGS-1 → 0).
  - ACK via WDATA_ACK, then back to WDATA.
- RDATA:
  - Shift register loads reg[pointer] at the falling edge that ends the ACK.
  - Drive each bit as sda_oe = ~bit, MSB first, changing on falling edges.
  - After 8 bits, release SDA → RD_MACK; pointer increments mod NUM_REGS.
- RD_MACK: sample the master bit on the rising edge. 0 (ACK) → RDATA with the next byte; 1 (NACK) → WAIT.
- WAIT: sda_oe=0; only START or STOP leave it.
- Repeated START in any state → ADDR. The pointer is kept, so write-pointer then repeated-START read returns reg[pointer].
- A partial byte before STOP/START is discarded; no register write, no wr_stb.
- ena falling mid-transfer behaves as a bus abort: → IDLE, sda_oe=0, registers kept.
- regs_o is registered and updates the cycle after the last data bit is sampled. No combinational path from pins to outputs.

Decomposition:
- Package i2c_pkg: state enum type, WL, ACK/NACK constants, and a function for pointer width ($clog2 wrapper).
- Sub-module i2c_sync_edge: SYNC_STAGES synchroniser plus edge/START/STOP detector for scl/sda. Outputs s_scl, s_sda, scl_rise, scl_fall, start_det, stop_det.
- The top holds the FSM, shift register, pointer and register file.

Test Plan:
- Write addr 0x2A, ptr 0x03, data 0xA5 then STOP → regs_o[3*8+:8]=0xA5. One wr_stb with wr_idx=3. Three ACKs observed (sda low on 9th clocks). busy falls after STOP.
- Burst write ptr 0x06, data 0x11,0x22,0x33 (NUM_REGS=8) → reg6=0x11, reg7=0x22, reg0=0x33 (wrap); three wr_stb pulses.
- Write ptr 0x06, repeated START, read 2 bytes with master ACK then NACK → bus reads 0x11,0x22. sda_oe=0 after the NACK; pointer then = 0.
- Address 0x2B write → no ACK (SDA high on 9th clock), no register change, busy stays 0, FSM idles until next START.
- Abort cases:
  - STOP after 4 data bits → no write, no wr_stb.
  - rst_n pulsed low mid-read → sda_oe=0 immediately and all regs 0.
- sda_oe toggles only while scl_i=0 across all above runs (assertion). ena=0 during a valid write → no ACK, no change.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    localparam int unsigned WL = 8;
    localparam int unsigned CW = 4;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_ADDR      = 4'd1;
    localparam state_t ST_ADDR_ACK  = 4'd2;
    localparam state_t ST_PTR       = 4'd3;
    localparam state_t ST_PTR_ACK   = 4'd4;
    localparam state_t ST_WDATA     = 4'd5;
    localparam state_t ST_WDATA_ACK = 4'd6;
    localparam state_t ST_RDATA     = 4'd7;
    localparam state_t ST_RD_MACK   = 4'd8;
    localparam state_t ST_WAIT      = 4'd9;

    // Register pointer width; at least one bit so a 1-entry file still has an index.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// SCL/SDA synchronisers followed by a registered edge, START and STOP detector.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic s_scl,
    output logic s_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_new;
    logic                   sda_new;

    assign scl_new = scl_sync[SYNC_STAGES-1];
    assign sda_new = sda_sync[SYNC_STAGES-1];

    // Edge flags are registered alongside s_scl/s_sda so they line up with the sampled levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            s_scl     <= 1'b1;
            s_sda     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            s_scl     <= scl_new;
            s_sda     <= sda_new;
            scl_rise  <= scl_new & ~s_scl;
            scl_fall  <= ~scl_new & s_scl;
            start_det <= scl_new & s_scl & s_sda & ~sda_new;
            stop_det  <= scl_new & s_scl & ~s_sda & sda_new;
        end
    end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with an auto-incrementing register file exposed as a flat bus.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h2A,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    input  logic                               scl_i,
    input  logic                               sda_i,
    output logic                               sda_oe,
    output logic [NUM_REGS*WL-1:0]             regs_o,
    output logic                               wr_stb,
    output logic [ptr_width(NUM_REGS)-1:0]     wr_idx,
    output logic                               busy
);

    localparam int unsigned PW       = ptr_width(NUM_REGS);
    localparam logic [CW-1:0] CNT_FULL = CW'(WL);

    logic s_scl, s_sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .s_scl     (s_scl),
        .s_sda     (s_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt, cnt_nxt;
    logic [WL-1:0]   shreg, shreg_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic            oe_nxt, busy_nxt, stb_nxt;
    logic [PW-1:0]   idx_nxt;
    logic            reg_we;
    logic [WL-1:0]   regs [NUM_REGS];
    logic [WL-1:0]   rx_byte;
    logic [WL-1:0]   rd_byte;
    logic            fall_ok;

    assign rx_byte = {shreg[WL-2:0], s_sda};
    assign rd_byte = regs[ptr];
    // SDA may only move once SCL is seen low.
    assign fall_ok = scl_fall & ~s_scl;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[k*WL +: WL] = regs[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_idx  <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            shreg   <= shreg_nxt;
            ptr     <= ptr_nxt;
            sda_oe  <= oe_nxt;
            busy    <= busy_nxt;
            wr_stb  <= stb_nxt;
            wr_idx  <= idx_nxt;
            if (reg_we) regs[ptr] <= rx_byte;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shreg_nxt = shreg;
        ptr_nxt   = ptr;
        oe_nxt    = sda_oe;
        busy_nxt  = busy;
        stb_nxt   = 1'b0;
        idx_nxt   = wr_idx;
        reg_we    = 1'b0;

        if (!ena || stop_det) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else if (start_det) begin
            state_nxt = ST_ADDR;
            cnt_nxt   = '0;
            oe_nxt    = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt < CNT_FULL) begin
                        shreg_nxt = rx_byte;
                        cnt_nxt   = bit_cnt + CW'(1);
                        if (state == ST_WDATA && bit_cnt == CNT_FULL - CW'(1)) begin
                            reg_we  = 1'b1;
                            stb_nxt = 1'b1;
                            idx_nxt = ptr;
                            ptr_nxt = ptr + PW'(1);
                        end
                    end else if (fall_ok && bit_cnt == CNT_FULL) begin
                        cnt_nxt = '0;
                        if (state == ST_ADDR) begin
                            if (shreg[WL-1:1] == DEV_ADDR) begin
                                state_nxt = ST_ADDR_ACK;
                                oe_nxt    = 1'b1;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = ST_WAIT;
                                busy_nxt  = 1'b0;
                            end
                        end else if (state == ST_PTR) begin
                            ptr_nxt   = PW'(shreg);
                            oe_nxt    = 1'b1;
                            state_nxt = ST_PTR_ACK;
                        end else begin
                            oe_nxt    = 1'b1;
                            state_nxt = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (fall_ok) begin
                        cnt_nxt = '0;
                        if (shreg[0]) begin
                            state_nxt = ST_RDATA;
                            shreg_nxt = rd_byte;
                            oe_nxt    = ~rd_byte[WL-1];
                        end else begin
                            state_nxt = ST_PTR;
                            oe_nxt    = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (fall_ok) begin
                        state_nxt = ST_WDATA;
                        cnt_nxt   = '0;
                        oe_nxt    = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && bit_cnt < CNT_FULL) begin
                        cnt_nxt = bit_cnt + CW'(1);
                    end else if (fall_ok && bit_cnt == CNT_FULL) begin
                        state_nxt = ST_RD_MACK;
                        cnt_nxt   = '0;
                        oe_nxt    = 1'b0;
                        ptr_nxt   = ptr + PW'(1);
                    end else if (fall_ok && bit_cnt != '0) begin
                        shreg_nxt = {shreg[WL-2:0], 1'b0};
                        oe_nxt    = ~shreg[WL-2];
                    end
                end
                ST_RD_MACK: begin
                    // bit_cnt==1 marks a master ACK seen on the rising edge.
                    if (scl_rise) begin
                        if (s_sda == NACK) begin
                            state_nxt = ST_WAIT;
                            busy_nxt  = 1'b0;
                        end else begin
                            cnt_nxt = CW'(1);
                        end
                    end else if (fall_ok && bit_cnt == CW'(1)) begin
                        state_nxt = ST_RDATA;
                        cnt_nxt   = '0;
                        shreg_nxt = rd_byte;
                        oe_nxt    = ~rd_byte[WL-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
